// File: rtl/sap1_serial_loader_if.sv
// Front-panel programming bus between the serial loader and the SAP-1 core,
// plus the loader status flags.
interface sap1_serial_loader_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  fp_prog;
    logic                  fp_write;
    logic [ADDR_WIDTH-1:0] fp_adr;
    logic [7:0]            fp_data;
    logic                  fp_clear;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output fp_prog, fp_write, fp_adr, fp_data, fp_clear, busy, done, error
    );

    modport slave (
        input fp_prog, fp_write, fp_adr, fp_data, fp_clear, busy, done, error
    );
endinterface

// File: rtl/sap1_serial_loader.sv
// SAP-1 serial program loader: 8N1 UART receiver feeding a frame FSM that
// writes 2**ADDR_WIDTH RAM words through the front panel, verifies an 8-bit
// wrap-around checksum and pulses fp_clear on success.
// Optional inter-byte timeout: define SAP1_LOADER_TIMEOUT_EN.
module sap1_serial_loader #(
    parameter int unsigned CLK_DIV        = 434,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned CLEAR_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 rx,
    sap1_serial_loader_if.master fp
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, CLEAR, DONE, ERROR} state_t;

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state, rx_state_nxt;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             byte_valid, byte_valid_nxt, byte_err, byte_err_nxt;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt, adr_nxt;
    logic [7:0]            sum, sum_nxt, data_nxt;
    logic                  wr_pend, wr_pend_nxt, last, last_nxt;
    logic [CLR_W-1:0]      clr_cnt, clr_cnt_nxt;
    logic                  prog_nxt, write_nxt, clear_nxt, busy_nxt, done_nxt, error_nxt;
    logic                  timeout;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_shift   <= rx_shift_nxt;
            byte_valid <= byte_valid_nxt;
            byte_err   <= byte_err_nxt;
        end
    end

    // Receiver next state: mid-start recheck, then one sample per bit period
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt + DIV_W'(1);
        rx_bit_nxt     = rx_bit;
        rx_shift_nxt   = rx_shift;
        byte_valid_nxt = 1'b0;
        byte_err_nxt   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == DIV_W'(CLK_DIV / 2 - 1)) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == DIV_W'(CLK_DIV - 1)) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == DIV_W'(CLK_DIV - 1)) begin
                    rx_cnt_nxt     = '0;
                    byte_valid_nxt = rx_sync;
                    byte_err_nxt   = !rx_sync;
                    rx_state_nxt   = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

`ifdef SAP1_LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Inter-byte idle counter, cleared by any received frame and held in IDLE
    always_ff @(posedge sysclk) begin
        if (!reset_n || state == IDLE || byte_valid || byte_err) begin
            tmo_cnt <= '0;
        end else if (!timeout) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timeout = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) && (state == LOAD || state == CHECK);
`else
    logic timeout_unused;
    assign timeout        = 1'b0;
    assign timeout_unused = (TIMEOUT_CYCLES == 0);
`endif

    // Loader state and registered front-panel outputs
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            sum         <= '0;
            wr_pend     <= 1'b0;
            last        <= 1'b0;
            clr_cnt     <= '0;
            fp.fp_prog  <= 1'b0;
            fp.fp_write <= 1'b0;
            fp.fp_adr   <= '0;
            fp.fp_data  <= '0;
            fp.fp_clear <= 1'b0;
            fp.busy     <= 1'b0;
            fp.done     <= 1'b0;
            fp.error    <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            sum         <= sum_nxt;
            wr_pend     <= wr_pend_nxt;
            last        <= last_nxt;
            clr_cnt     <= clr_cnt_nxt;
            fp.fp_prog  <= prog_nxt;
            fp.fp_write <= write_nxt;
            fp.fp_adr   <= adr_nxt;
            fp.fp_data  <= data_nxt;
            fp.fp_clear <= clear_nxt;
            fp.busy     <= busy_nxt;
            fp.done     <= done_nxt;
            fp.error    <= error_nxt;
        end
    end

    // Loader next state; a data byte sets adr/data first, strobes a cycle later
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        sum_nxt     = sum;
        wr_pend_nxt = wr_pend;
        last_nxt    = last;
        clr_cnt_nxt = clr_cnt;
        adr_nxt     = fp.fp_adr;
        data_nxt    = fp.fp_data;
        prog_nxt    = fp.fp_prog;
        write_nxt   = 1'b0;
        clear_nxt   = fp.fp_clear;
        busy_nxt    = fp.busy;
        done_nxt    = fp.done;
        error_nxt   = fp.error;
        case (state)
            IDLE: begin
                if (byte_valid && rx_shift == SYNC_BYTE) begin
                    state_nxt   = LOAD;
                    busy_nxt    = 1'b1;
                    prog_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    error_nxt   = 1'b0;
                    idx_nxt     = '0;
                    sum_nxt     = '0;
                    wr_pend_nxt = 1'b0;
                    last_nxt    = 1'b0;
                end
            end
            LOAD: begin
                if (byte_err || timeout) begin
                    state_nxt = ERROR;
                end else if (wr_pend) begin
                    write_nxt   = 1'b1;
                    wr_pend_nxt = 1'b0;
                end else if (fp.fp_write) begin
                    if (last) state_nxt = CHECK;
                end else if (byte_valid) begin
                    adr_nxt     = idx;
                    data_nxt    = rx_shift;
                    sum_nxt     = sum + rx_shift;
                    idx_nxt     = idx + ADDR_WIDTH'(1);
                    last_nxt    = (idx == '1);
                    wr_pend_nxt = 1'b1;
                end
            end
            CHECK: begin
                if (byte_err || timeout) begin
                    state_nxt = ERROR;
                end else if (byte_valid) begin
                    if (rx_shift == sum) begin
                        state_nxt   = CLEAR;
                        prog_nxt    = 1'b0;
                        clear_nxt   = 1'b1;
                        clr_cnt_nxt = '0;
                    end else begin
                        state_nxt = ERROR;
                    end
                end
            end
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + CLR_W'(1);
                if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
                    clear_nxt = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            ERROR: begin
                prog_nxt  = 1'b0;
                error_nxt = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/sap1_serial_loader.md
Name: sap1_serial_loader

Overview:
- Upstream stage of the SAP-1 core. Receives a program image over a UART line and drives the core's front-panel programming inputs: fp_prog, fp_write, fp_adr and fp_data.
- Writes all 16 RAM words, verifies a checksum, then pulses fp_clear so the core restarts from address 0.
- Replaces manual switch entry on the devboard. The core runs untouched between loads.

Parameters:
- CLK_DIV, 434, sysclk cycles per UART bit (50 MHz / 115200).
- ADDR_WIDTH, 4, RAM address width. The image length is 2**ADDR_WIDTH bytes.
- SYNC_BYTE, 8'hA5, frame header byte.
- CLEAR_CYCLES, 4, length of the fp_clear pulse in sysclk cycles.
- TIMEOUT_CYCLES, 5_000_000, inter-byte timeout. Used only with the optional feature.

Ports:
- sysclk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous UART receive line, idle high.
- fp_prog  output  1  high while the loader owns RAM; muxes fp_adr into the RAM address.
- fp_write  output  1  one-cycle RAM write strobe.
- fp_adr  output  ADDR_WIDTH  RAM write address.
- fp_data  output  8  RAM write data.
- fp_clear  output  1  core clear pulse after a successful load.
- busy  output  1  high from the accepted sync byte until DONE or ERROR.
- done  output  1  sticky; the last load succeeded.
- error  output  1  sticky; the last load failed.

Behaviour:
- Reset: one clock (sysclk); synchronous, active-low reset (reset_n). Sampled on the sysclk rising edge.
  - All outputs are 0 in reset, fp_adr = 0 and fp_data = 0.
  - The FSM enters IDLE and the receiver enters RX_IDLE.
  - Reset mid-load drops fp_prog immediately on that edge, with no partial-write cleanup.
- rx synchroniser: two flops, reset value 1.
- UART receiver, 8N1, LSB first:
  - Start: a falling edge on the synced rx starts a bit counter.
  - At CLK_DIV/2 the start bit is re-checked. If rx is high, it was a glitch: return to RX_IDLE.
  - Each of the 8 data bits is sampled every CLK_DIV cycles after that point.
  - Stop bit is sampled one CLK_DIV later. If high, a 1-cycle byte_valid is raised with the byte.
  - If the stop bit is low, byte_err is pulsed instead and the byte is dropped.
  - The receiver returns to RX_IDLE at the stop-bit sample point, so back-to-back frames are accepted.
- Main FSM states: IDLE, LOAD, CHECK, CLEAR, DONE, ERROR.
  - IDLE: waits for byte_valid with byte == SYNC_BYTE; any other byte is ignored.
    - On sync: busy = 1, fp_prog = 1, done = 0, error = 0, word index = 0, checksum = 0, go to LOAD.
  - LOAD, on each byte_valid:
    - fp_adr = index, fp_data = byte, checksum += byte (mod 256).
    - fp_write = 1 on the following cycle only, with fp_adr and fp_data already stable that cycle and held after.
    - index increments. After the write of index 2**ADDR_WIDTH-1, go to CHECK.
  - CHECK: the next byte_valid is compared with the running checksum.
    - Equal: go to CLEAR.
    - Not equal: go to ERROR.
  - CLEAR: fp_prog = 0 and fp_clear = 1 for exactly CLEAR_CYCLES cycles, then go to DONE.
  - DONE: done = 1, busy = 0, return to IDLE on the same cycle.
  - ERROR: fp_prog = 0, error = 1, busy = 0, no fp_clear pulse, return to IDLE.
- Any byte_err while busy (LOAD or CHECK) forces ERROR. A byte_err in IDLE is ignored.
- A SYNC_BYTE value inside LOAD is treated as data; there is no resync mid-frame.
- fp_write never asserts outside LOAD. fp_write and fp_clear are never high together.
- done and error are mutually exclusive. Both clear only on the next accepted sync byte.
- Checksum is an 8-bit wrap-around sum of the 16 data bytes; the sync byte is excluded.

Optional Feature:
- Macro: SAP1_LOADER_TIMEOUT_EN.
- Defined:
  - A counter resets on every byte_valid and byte_err.
  - In LOAD or CHECK, reaching TIMEOUT_CYCLES with no byte forces ERROR.
  - The counter is held at 0 in IDLE.
- Undefined:
  - No counter is built, and a stalled frame leaves the loader in LOAD indefinitely with fp_prog = 1.
  - The TIMEOUT_CYCLES parameter is present but unused.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with rx toggling -> all outputs 0, no fp_write; after release the first byte 8'h00 is ignored.
- Good load (CLK_DIV = 8 for sim): send A5, then 00..0F, then checksum 8'h78 ->
  - 16 fp_write pulses, one per data byte, with fp_adr = fp_data = 0..F.
  - fp_prog high from sync to checksum; fp_clear high exactly 4 cycles; done = 1, error = 0.
- Bad checksum: same frame with checksum 8'h77 -> 16 writes occur, no fp_clear, error = 1, fp_prog = 0.
- Framing error: A5, 3 good bytes, then a byte with stop bit 0 -> ERROR after 3 writes; the next A5 clears error and busy = 1.
- Glitch and sync filtering:
  - A 2-cycle low pulse on rx -> no byte_valid.
  - Bytes 11 and 22 in IDLE -> ignored; fp_prog stays 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 200): A5 followed by 5 bytes, then rx idle -> error = 1 at 200 cycles after the last stop-bit sample, with 5 writes done.
